// File: rtl/axis_arb_pkg.sv
// Shared types and limits for the AXI-Stream round-robin arbiter.
package axis_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  localparam int MAX_NUM_REQ = 16;

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle: valid/ready handshake plus data.
interface axis_if #(
  parameter int TDATA_WIDTH = 8
) ();

  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  modport s (input tvalid, input tdata, output tready);
  modport m (output tvalid, output tdata, input tready);

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set bit of valid after ptr,
// wrapping modulo NUM_REQ, so the requester at ptr has lowest priority.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!any && valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-Stream arbiter with burst lock and registered output.
// Define AXIS_RR_ARBITER_SRCID_EN to add the m_srcid output.
//   state | meaning
//   ARB   | search all requesters starting after ptr
//   HOLD  | locked to owner until MAX_BURST beats or owner drops tvalid
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 4,
  parameter int TDATA_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  axis_if.s    axis_sif [NUM_REQ],
  axis_if.m    axis_mif,
  input  logic invalidate,
  output logic busy
`ifdef AXIS_RR_ARBITER_SRCID_EN
  ,
  output logic [$clog2(NUM_REQ)-1:0] m_srcid
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
    $fatal(1, "axis_rr_arbiter: NUM_REQ out of range");
  end
  if (MAX_BURST < 1 || MAX_BURST > 256) begin : g_bad_max_burst
    $fatal(1, "axis_rr_arbiter: MAX_BURST out of range");
  end
  if (axis_mif.TDATA_WIDTH != TDATA_WIDTH) begin : g_bad_mif_width
    $fatal(1, "axis_rr_arbiter: axis_mif TDATA_WIDTH mismatch");
  end

  logic [NUM_REQ-1:0]     s_valid;
  logic [TDATA_WIDTH-1:0] s_data [NUM_REQ];
  logic [NUM_REQ-1:0]     s_ready;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_sif
    if (axis_sif[g].TDATA_WIDTH != TDATA_WIDTH) begin : g_bad_sif_width
      $fatal(1, "axis_rr_arbiter: axis_sif TDATA_WIDTH mismatch");
    end
    assign s_valid[g]         = axis_sif[g].tvalid;
    assign s_data[g]          = axis_sif[g].tdata;
    assign axis_sif[g].tready = s_ready[g];
  end

  arb_state_e             state, state_nxt;
  logic [CNT_W-1:0]       count, count_nxt;
  logic [IDX_W-1:0]       ptr, ptr_nxt;
  logic [IDX_W-1:0]       owner, owner_nxt;
  logic                   m_valid;
  logic [TDATA_WIDTH-1:0] m_data;

  logic                   owner_valid;
  logic                   continuing;
  logic [IDX_W-1:0]       pick_ptr;
  logic [NUM_REQ-1:0]     pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [NUM_REQ-1:0]     grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_any;
  logic                   stall;
  logic                   can_accept;
  logic                   accept;

  assign owner_valid = s_valid[owner];
  assign continuing  = (state == HOLD) && owner_valid;
  // An owner that drops out searches from itself, so it becomes lowest priority.
  assign pick_ptr    = (state == HOLD) ? owner : ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid (s_valid),
    .ptr   (pick_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign grant     = continuing ? (NUM_REQ'(1) << owner) : pick_grant;
  assign grant_idx = continuing ? owner : pick_idx;
  assign grant_any = continuing | pick_any;

  assign stall      = m_valid && !axis_mif.tready;
  assign can_accept = (!m_valid || axis_mif.tready) && !invalidate && rst_n;
  assign accept     = grant_any && can_accept;
  assign s_ready    = grant & {NUM_REQ{can_accept}};

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    if (invalidate) begin
      state_nxt = ARB;
      count_nxt = '0;
    end else if (accept) begin
      if (continuing) begin
        if (count == CNT_W'(MAX_BURST - 1)) begin
          ptr_nxt   = owner;
          count_nxt = '0;
          state_nxt = ARB;
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end else begin
        owner_nxt = pick_idx;
        count_nxt = CNT_W'(1);
        if (state == HOLD) ptr_nxt = owner;
        if (MAX_BURST > 1) begin
          state_nxt = HOLD;
        end else begin
          state_nxt = ARB;
          ptr_nxt   = pick_idx;
        end
      end
    end else if (!stall && state == HOLD && !owner_valid) begin
      ptr_nxt   = owner;
      count_nxt = '0;
      state_nxt = ARB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
      count <= '0;
      ptr   <= IDX_W'(NUM_REQ - 1);
      owner <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (invalidate) begin
      m_valid <= 1'b0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_data  <= s_data[grant_idx];
    end else if (axis_mif.tready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef AXIS_RR_ARBITER_SRCID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_srcid <= '0;
    end else if (!invalidate && accept) begin
      m_srcid <= grant_idx;
    end
  end
`endif

  assign axis_mif.tvalid = m_valid;
  assign axis_mif.tdata  = m_data;
  assign busy            = m_valid || (state == HOLD);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter (NUM_REQ=4, MAX_BURST=4, 8-bit data).
module tb_axis_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       invalidate;
  logic       busy;
  logic [3:0] s_valid;
  logic [7:0] s_data [4];
  logic [3:0] s_ready;
  logic       m_ready;
  logic       m_valid;
  logic [7:0] m_data;
`ifdef AXIS_RR_ARBITER_SRCID_EN
  logic [1:0] m_srcid;
`endif

  logic [3:0] seq [4];
  logic [3:0] hs;
  int n_cmp;
  int n_fail;

  axis_if #(.TDATA_WIDTH(8)) sif [4] ();
  axis_if #(.TDATA_WIDTH(8)) mif ();

  for (genvar g = 0; g < 4; g++) begin : g_src
    assign sif[g].tvalid = s_valid[g];
    assign sif[g].tdata  = s_data[g];
    assign s_ready[g]    = sif[g].tready;
  end
  assign mif.tready = m_ready;
  assign m_valid    = mif.tvalid;
  assign m_data     = mif.tdata;

  axis_rr_arbiter #(
    .NUM_REQ     (4),
    .MAX_BURST   (4),
    .TDATA_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .axis_sif   (sif),
    .axis_mif   (mif),
    .invalidate (invalidate),
    .busy       (busy)
`ifdef AXIS_RR_ARBITER_SRCID_EN
    ,
    .m_srcid    (m_srcid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Each source presents {source index, beat number}.
  task automatic drive_data();
    for (int i = 0; i < 4; i++) s_data[i] = {4'(i), seq[i]};
  endtask

  task automatic step_update();
    for (int i = 0; i < 4; i++) if (hs[i]) seq[i] = seq[i] + 4'd1;
    drive_data();
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    s_valid    = 4'h0;
    invalidate = 1'b0;
    m_ready    = 1'b1;
    hs         = 4'h0;
    for (int i = 0; i < 4; i++) seq[i] = 4'd0;
    drive_data();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One granted cycle: check ready at negedge, output register after posedge.
  task automatic beat(input string name, input int src, input logic [7:0] exp_d);
    logic [3:0] exp_r;
    exp_r = 4'b0001 << src;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== exp_r) begin
      n_fail++;
      $display("FAIL %s ready: got=%b exp=%b", name, s_ready, exp_r);
    end
    hs = s_ready & s_valid;
    @(posedge clk);
    #1;
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== exp_d) begin
      n_fail++;
      $display("FAIL %s mif: got valid=%b data=%h exp valid=1 data=%h", name, m_valid, m_data, exp_d);
    end
`ifdef AXIS_RR_ARBITER_SRCID_EN
    n_cmp++;
    if (m_srcid !== 2'(src)) begin
      n_fail++;
      $display("FAIL %s srcid: got=%0d exp=%0d", name, m_srcid, src);
    end
`endif
    step_update();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    invalidate = 1'b0;
    m_ready    = 1'b1;
    s_valid    = 4'hF;
    for (int i = 0; i < 4; i++) seq[i] = 4'd0;
    drive_data();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got=%b exp=0", m_valid); end
    n_cmp++;
    if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_tdata: got=%h exp=00", m_data); end
    n_cmp++;
    if (s_ready !== 4'h0) begin n_fail++; $display("FAIL reset_tready: got=%b exp=0000", s_ready); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got=%b exp=0", busy); end
`ifdef AXIS_RR_ARBITER_SRCID_EN
    n_cmp++;
    if (m_srcid !== 2'd0) begin n_fail++; $display("FAIL reset_srcid: got=%0d exp=0", m_srcid); end
`endif
  endtask

  task automatic test_all_valid();
    int es;
    int eq;
    do_reset();
    s_valid = 4'hF;
    for (int k = 0; k < 17; k++) begin
      es = (k / 4) % 4;
      eq = (k / 16) * 4 + k % 4;
      beat("all_valid", es, 8'(es * 16 + eq));
    end
  endtask

  task automatic test_single();
    logic [7:0] vals [3];
    vals[0] = 8'hA1; vals[1] = 8'hA2; vals[2] = 8'hA3;
    do_reset();
    s_data[2] = vals[0];
    s_valid   = 4'b0100;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n_cmp++;
      if (s_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got=%b exp=0100", s_ready); end
      @(posedge clk);
      #1;
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== vals[j]) begin
        n_fail++;
        $display("FAIL single_mif: got valid=%b data=%h exp valid=1 data=%h", m_valid, m_data, vals[j]);
      end
`ifdef AXIS_RR_ARBITER_SRCID_EN
      n_cmp++;
      if (m_srcid !== 2'd2) begin n_fail++; $display("FAIL single_srcid: got=%0d exp=2", m_srcid); end
`endif
      if (j < 2) s_data[2] = vals[j+1];
      else s_valid = 4'h0;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: got valid=%b busy=%b exp valid=0 busy=0", m_valid, busy);
    end
    s_valid = 4'hF;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 4'b1000) begin n_fail++; $display("FAIL single_next_ptr: got=%b exp=1000", s_ready); end
  endtask

  task automatic test_handover();
    do_reset();
    s_valid = 4'b0011;
    beat("handover_b0", 0, 8'h00);
    beat("handover_b1", 0, 8'h01);
    s_valid = 4'b0010;
    beat("handover_switch", 1, 8'h10);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL handover_busy: got=%b exp=1", busy); end
    s_valid = 4'b0011;
    beat("handover_new_owner", 1, 8'h11);
  endtask

  task automatic test_stall();
    do_reset();
    s_valid = 4'hF;
    beat("stall_b0", 0, 8'h00);
    beat("stall_b1", 0, 8'h01);
    m_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      n_cmp++;
      if (s_ready !== 4'h0) begin n_fail++; $display("FAIL stall_ready c%0d: got=%b exp=0000", j, s_ready); end
      @(posedge clk);
      #1;
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== 8'h01 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold c%0d: got valid=%b data=%h busy=%b exp valid=1 data=01 busy=1", j, m_valid, m_data, busy);
      end
    end
    m_ready = 1'b1;
    beat("stall_resume_b2", 0, 8'h02);
    beat("stall_resume_b3", 0, 8'h03);
    beat("stall_next_src", 1, 8'h10);
  endtask

  task automatic test_invalidate();
    do_reset();
    s_valid = 4'hF;
    beat("inv_b0", 0, 8'h00);
    beat("inv_b1", 0, 8'h01);
    invalidate = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 4'h0) begin n_fail++; $display("FAIL inv_ready: got=%b exp=0000", s_ready); end
    @(posedge clk);
    #1;
    n_cmp++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL inv_flush: got valid=%b busy=%b exp valid=0 busy=0", m_valid, busy);
    end
    invalidate = 1'b0;
    beat("inv_after_b0", 0, 8'h02);
    beat("inv_after_b1", 0, 8'h03);
    beat("inv_after_b2", 0, 8'h04);
    beat("inv_after_b3", 0, 8'h05);
    beat("inv_after_next", 1, 8'h10);
  endtask

  task automatic test_reset_mid();
    do_reset();
    s_valid = 4'hF;
    for (int k = 0; k < 6; k++) beat("rstmid_pre", k / 4, 8'((k / 4) * 16 + k % 4));
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 4'h0) begin
      n_fail++;
      $display("FAIL rstmid_async: got valid=%b busy=%b ready=%b exp 0 0 0000", m_valid, busy, s_ready);
    end
    for (int i = 0; i < 4; i++) seq[i] = 4'd0;
    drive_data();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    beat("rstmid_first", 0, 8'h00);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_all_valid();
    test_single();
    test_handover();
    test_stall();
    test_invalidate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
